e1_tick_cap_wb: RTL

Wishbone peripheral on the external SoC peripheral bus that consumes the per-line E1 RX/TX tick strobes and the USB SOF tick produced by the SoC base. Each E1 line has free-running RX and TX tick counters, and every USB SOF atomically snapshots them together with a system-clock cycle count. Firmware uses the snapshots to measure E1 line rate against the USB 1 ms frame and steer buffer fill levels.

---
 rtl/e1_tick_cap_wb.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/e1_tick_cap_wb.sv
// E1 RX/TX tick counters with USB-SOF-synchronous snapshot.
// Wishbone register file for line-rate measurement against the 1 ms frame.
module e1_tick_cap_wb #(
  parameter int E1_N = 1,
  parameter int TW   = 16,
  parameter int YW   = 24
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [E1_N-1:0] tick_e1_rx,
  input  logic [E1_N-1:0] tick_e1_tx,
  input  logic            tick_usb_sof,
  input  logic [2:0]      wb_addr,
  output logic [31:0]     wb_rdata,
  input  logic [31:0]     wb_wdata,
  input  logic            wb_we,
  input  logic            wb_cyc,
  output logic            wb_ack
);

  logic            ack_q, ack_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            en_q, en_d;
  logic            capv_q, capv_d;
  logic            ovr_q, ovr_d;
  logic [15:0]     sof_cnt_q, sof_cnt_d;
  logic [YW-1:0]   cyc_q, cyc_d;
  logic [YW-1:0]   cyc_cap_q, cyc_cap_d;
  logic [YW-1:0]   cyc_inc;

  logic [TW-1:0]   rx_cnt_q [E1_N];
  logic [TW-1:0]   rx_cnt_d [E1_N];
  logic [TW-1:0]   tx_cnt_q [E1_N];
  logic [TW-1:0]   tx_cnt_d [E1_N];
  logic [TW-1:0]   rx_cap_q [E1_N];
  logic [TW-1:0]   rx_cap_d [E1_N];
  logic [TW-1:0]   tx_cap_q [E1_N];
  logic [TW-1:0]   tx_cap_d [E1_N];
  logic [TW-1:0]   rx_nxt   [E1_N];
  logic [TW-1:0]   tx_nxt   [E1_N];

  logic            acc;
  logic            ctrl_wr;
  logic            ctrl_rd;
  logic            clr;
  logic            en_rise;
  logic            cap;
  logic [31:0]     rd_word;
  logic            wdata_unused;

  assign wdata_unused = ^wb_wdata[31:2];

  // Bus strobes; every access lands on the edge that raises ack.
  always_comb begin
    acc     = wb_cyc & ~ack_q;
    ack_d   = acc;
    ctrl_wr = acc & wb_we & (wb_addr == 3'd0);
    ctrl_rd = acc & ~wb_we & (wb_addr == 3'd0);
    clr     = ctrl_wr & wb_wdata[1];
    en_rise = ctrl_wr & wb_wdata[0] & ~en_q;
    cap     = tick_usb_sof & en_q;
  end

  always_comb begin
    en_d = en_q;
    if (ctrl_wr) begin
      en_d = wb_wdata[0];
    end
  end

  // Cycle counter saturates; capture uses the incremented value.
  always_comb begin
    cyc_inc = (cyc_q == {YW{1'b1}}) ? cyc_q : cyc_q + YW'(1);
    cyc_d   = cyc_q;
    if (en_q) begin
      cyc_d = cyc_inc;
    end
    if (cap || en_rise || clr) begin
      cyc_d = '0;
    end
  end

  always_comb begin
    cyc_cap_d = cyc_cap_q;
    sof_cnt_d = sof_cnt_q;
    capv_d    = capv_q;
    ovr_d     = ovr_q;
    if (clr) begin
      cyc_cap_d = '0;
      sof_cnt_d = '0;
      capv_d    = 1'b0;
      ovr_d     = 1'b0;
    end else if (cap) begin
      cyc_cap_d = cyc_inc;
      sof_cnt_d = sof_cnt_q + 16'd1;
      capv_d    = 1'b1;
      ovr_d     = ovr_q | capv_q;
    end else if (ctrl_rd) begin
      capv_d    = 1'b0;
      ovr_d     = 1'b0;
    end
  end

  // Snapshot includes a tick that arrives on the SOF cycle.
  always_comb begin
    for (int n = 0; n < E1_N; n++) begin
      rx_nxt[n]   = rx_cnt_q[n] + TW'(tick_e1_rx[n]);
      tx_nxt[n]   = tx_cnt_q[n] + TW'(tick_e1_tx[n]);
      rx_cnt_d[n] = rx_cnt_q[n];
      tx_cnt_d[n] = tx_cnt_q[n];
      rx_cap_d[n] = rx_cap_q[n];
      tx_cap_d[n] = tx_cap_q[n];
      if (clr) begin
        rx_cnt_d[n] = '0;
        tx_cnt_d[n] = '0;
        rx_cap_d[n] = '0;
        tx_cap_d[n] = '0;
      end else if (en_q) begin
        rx_cnt_d[n] = rx_nxt[n];
        tx_cnt_d[n] = tx_nxt[n];
        if (cap) begin
          rx_cap_d[n] = rx_nxt[n];
          tx_cap_d[n] = tx_nxt[n];
        end
      end
    end
  end

  always_comb begin
    rd_word = '0;
    case (wb_addr)
      3'd0: rd_word = {22'd0, ovr_q, capv_q, 7'd0, en_q};
      3'd1: rd_word = {16'd0, sof_cnt_q};
      3'd2: rd_word = 32'(cyc_cap_q);
      default: begin
        for (int n = 0; n < E1_N; n++) begin
          if (wb_addr == 3'(4 + n)) begin
            rd_word = 32'(rx_cap_q[n]) | (32'(tx_cap_q[n]) << 16);
          end
        end
      end
    endcase
    rdata_d = (acc & ~wb_we) ? rd_word : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      en_q      <= 1'b0;
      capv_q    <= 1'b0;
      ovr_q     <= 1'b0;
      sof_cnt_q <= '0;
      cyc_q     <= '0;
      cyc_cap_q <= '0;
      for (int n = 0; n < E1_N; n++) begin
        rx_cnt_q[n] <= '0;
        tx_cnt_q[n] <= '0;
        rx_cap_q[n] <= '0;
        tx_cap_q[n] <= '0;
      end
    end else begin
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      en_q      <= en_d;
      capv_q    <= capv_d;
      ovr_q     <= ovr_d;
      sof_cnt_q <= sof_cnt_d;
      cyc_q     <= cyc_d;
      cyc_cap_q <= cyc_cap_d;
      for (int n = 0; n < E1_N; n++) begin
        rx_cnt_q[n] <= rx_cnt_d[n];
        tx_cnt_q[n] <= tx_cnt_d[n];
        rx_cap_q[n] <= rx_cap_d[n];
        tx_cap_q[n] <= tx_cap_d[n];
      end
    end
  end

  assign wb_ack   = ack_q;
  assign wb_rdata = rdata_q;

endmodule
